// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a fixed-latency start/busy/done handshake.
// One radix-2 step per cycle: shift-add multiply or restoring divide on operand magnitudes.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count;
  logic [2:0]      opr;
  logic [XLEN-1:0] hi, lo, d;
  logic            neg_q, neg_r, bzero;

  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum;
  logic [XLEN+1:0] div_trial;
  logic            div_ge;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quot_s, rem_s, fix_val;

  // Operand conditioning for the request presented in IDLE
  always_comb begin
    a_sgn = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_sgn = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg = a_sgn & a[XLEN-1];
    b_neg = b_sgn & b[XLEN-1];
    a_mag = a_neg ? ('0 - a) : a;
    b_mag = b_neg ? ('0 - b) : b;
  end

  // Multiply: hi accumulates, lo holds the multiplier bits being consumed.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
    div_trial = {1'b0, hi, lo[XLEN-1]} - {2'b00, d};
    div_ge    = ~div_trial[XLEN+1];
  end

  always_comb begin
    prod   = {hi, lo};
    prod_s = neg_q ? ('0 - prod) : prod;
    quot_s = bzero ? '1 : (neg_q ? ('0 - lo) : lo);
    rem_s  = neg_r ? ('0 - hi) : hi;
    fix_val = '0;
    case (opr)
      3'd0:          fix_val = prod_s[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          fix_val = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:    fix_val = quot_s;
      default:       fix_val = rem_s;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && !flush) state_next = CALC;
      CALC: if (count == CW'(XLEN-1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush && state != IDLE) state_next = IDLE;
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      opr    <= '0;
      hi     <= '0;
      lo     <= '0;
      d      <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      bzero  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start && !flush) begin
          opr   <= op;
          hi    <= '0;
          lo    <= a_mag;
          d     <= b_mag;
          count <= '0;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          bzero <= (b == '0);
        end
        CALC: begin
          count <= count + 1'b1;
          if (opr[2]) begin
            hi <= div_ge ? div_trial[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]};
            lo <= {lo[XLEN-2:0], div_ge};
          end else begin
            {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
          end
        end
        FIX: if (!flush) result <= fix_val;
        default: ;
      endcase
    end
  end

endmodule
